adc_result_averager: RTL and testbench
======================================

ADC_RESULT_AVERAGER -- requirements
Module: adc_result_averager

Interface
REQ-001 Parameter IN_WIDTH, default 12: width of one raw conversion result.
REQ-002 Parameter AVG_LOG2_MAX, default 7: largest supported log2 of samples per average; the accumulator is IN_WIDTH+AVG_LOG2_MAX bits.
REQ-003 Port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-low.
REQ-005 Port en  input  1  averaging enable; low aborts the current block.
REQ-006 Port conv_finished  input  1  conversion-done level from the SAR controller; one sample event per rising edge.
REQ-007 Port result  input  IN_WIDTH  raw conversion result; valid while conv_finished is high.
REQ-008 Port avg_control  input  3  log2 of samples per output word (0 = 1 sample, 7 = 128 samples).
REQ-009 Port data_ready  input  1  downstream accepts data_out when high together with data_valid.
REQ-010 Port clear_overrun  input  1  synchronous clear of overrun.
REQ-011 Port data_out  output  IN_WIDTH  averaged result.
REQ-012 Port data_valid  output  1  data_out holds an unconsumed average.
REQ-013 Port busy  output  1  a block is partially accumulated.
REQ-014 Port overrun  output  1  sticky flag: a completed average was dropped.

Function
REQ-015 Sample event = conv_finished high and its registered previous value low; result is captured on the same edge.
REQ-016 FSM states IDLE (count 0, acc 0) and ACCUM; IDLE->ACCUM on the first sample event with en high; ACCUM->IDLE when the block completes or en is low.
REQ-017 On the first event of a block, avg_control is latched as shift; changes to avg_control during a block are ignored until the next block.
REQ-018 Block size N = 2^shift; each event adds zero-extended result to acc and increments count.
REQ-019 On the Nth event: data_out <= (acc + result) >> shift (truncation, lower IN_WIDTH bits); acc and count clear on that same edge.
REQ-020 With shift = 0 every event completes a block; data_out = result, no accumulator state retained.
REQ-021 data_valid rises on the same edge that loads data_out; latency one edge from the sampling edge of the final event.
REQ-022 data_out and data_valid are held stable while data_valid is high and data_ready is low.
REQ-023 data_valid clears on the edge where data_valid and data_ready are both high, unless a new block completes on that same edge, in which case data_out reloads and data_valid stays high.
REQ-024 A block completing while data_valid is high and data_ready is low is discarded; data_out is kept; overrun sets.
REQ-025 overrun stays high until clear_overrun is high on an edge; simultaneous set and clear gives set.
REQ-026 en low: acc, count and FSM return to IDLE on the next edge; sample events are ignored; data_out, data_valid and overrun are unaffected; handshake continues.
REQ-027 busy = (state == ACCUM).
REQ-028 The accumulator never wraps: maximum sum 128 x (2^IN_WIDTH - 1) fits IN_WIDTH+7 bits.

Reset
REQ-029 On rst low, asynchronously: data_out = 0, data_valid = 0, busy = 0, overrun = 0, acc = 0, count = 0, shift = 0, previous conv_finished = 0, FSM = IDLE.
REQ-030 After rst is released, the first sample event requires conv_finished to be seen low for at least one edge; a level already high at release is not counted.
REQ-031 Reset mid-block discards the partial sum; no output is produced for it.

Verification
REQ-032 avg_control=0, data_ready=1, results 0x123, 0xFFF -> two data_valid pulses carrying 0x123 then 0xFFF.
REQ-033 avg_control=2, results 10,11,12,13 -> data_out=11 (46>>2), busy high from event 1 until event 4.
REQ-034 avg_control=7, 128 events of 0xFFF -> data_out=0xFFF, no wrap.
REQ-035 data_ready=0, avg_control=0, two events -> data_out keeps the first value, overrun=1; clear_overrun pulse -> overrun=0.
REQ-036 avg_control=2, en dropped after 2 events, then 4 events of 5 with en high -> data_out=5, first partial sum discarded.
REQ-037 rst asserted after 3 of 4 events -> all outputs 0 immediately; the next 4 events produce a correct fresh average.

Source files
------------

// File: rtl/adc_result_averager.sv
// adc_result_averager
// Averages 2^shift consecutive SAR conversion results into one output word
// and offers it downstream through a valid/ready handshake. A completed
// average that cannot be delivered is dropped and flagged in a sticky
// overrun bit.

module adc_result_averager #(
   parameter int IN_WIDTH     = 12,
   parameter int AVG_LOG2_MAX = 7
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                conv_finished,
   input  logic [IN_WIDTH-1:0] result,
   input  logic [2:0]          avg_control,
   input  logic                data_ready,
   input  logic                clear_overrun,
   output logic [IN_WIDTH-1:0] data_out,
   output logic                data_valid,
   output logic                busy,
   output logic                overrun
);

   // The largest block sum, 2^AVG_LOG2_MAX full-scale results, fits exactly.
   localparam int ACC_W = IN_WIDTH + AVG_LOG2_MAX;
   localparam int CNT_W = (AVG_LOG2_MAX > 0) ? AVG_LOG2_MAX : 1;

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t              state_q, state_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [2:0]          shift_q, shift_d;
   logic                conv_q;
   logic                armed_q;
   logic [IN_WIDTH-1:0] data_out_q, data_out_d;
   logic                valid_q, valid_d;
   logic                overrun_q, overrun_d;

   logic                sample_ev;
   logic                accept;
   logic                last_ev;
   logic                overrun_set;
   logic [2:0]          req_shift;
   logic [2:0]          eff_shift;
   logic [CNT_W-1:0]    count_limit;
   logic [ACC_W-1:0]    sum;
   logic [ACC_W-1:0]    avg_full;

   // Rising edge of the conversion-done level. armed_q keeps a level that is
   // already high when reset releases from counting as an event.
   assign sample_ev = conv_finished & ~conv_q & armed_q;
   assign accept    = valid_q & data_ready;

   // Block geometry: a new block takes its size from avg_control, a running
   // block keeps the size it latched on its first event.
   assign req_shift   = (int'(avg_control) > AVG_LOG2_MAX) ? 3'(AVG_LOG2_MAX) : avg_control;
   assign eff_shift   = (state_q == IDLE) ? req_shift : shift_q;
   assign count_limit = CNT_W'((32'd1 << eff_shift) - 32'd1);
   assign last_ev     = (count_q == count_limit);
   assign sum         = acc_q + ACC_W'(result);
   assign avg_full    = sum >> eff_shift;

   // Next-state computation for the accumulator FSM and the output handshake.
   always_comb begin
      // NOTE: every _d starts from its _q so no path leaves a value unassigned,
      // which would otherwise infer a latch.
      state_d     = state_q;
      acc_d       = acc_q;
      count_d     = count_q;
      shift_d     = shift_q;
      data_out_d  = data_out_q;
      valid_d     = valid_q;
      overrun_set = 1'b0;

      if (accept) begin
         valid_d = 1'b0;
      end

      if (!en) begin
         state_d = IDLE;
         acc_d   = '0;
         count_d = '0;
      end else if (sample_ev) begin
         if (state_q == IDLE) begin
            shift_d = req_shift;
         end
         if (last_ev) begin
            state_d = IDLE;
            acc_d   = '0;
            count_d = '0;
            // Deliver unless an unconsumed word is still being held.
            if (!valid_q || data_ready) begin
               data_out_d = avg_full[IN_WIDTH-1:0];
               valid_d    = 1'b1;
            end else begin
               overrun_set = 1'b1;
            end
         end else begin
            state_d = ACCUM;
            acc_d   = sum;
            count_d = count_q + CNT_W'(1);
         end
      end

      // A new drop wins over a simultaneous clear request.
      overrun_d = overrun_set | (overrun_q & ~clear_overrun);
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         count_q    <= '0;
         shift_q    <= '0;
         conv_q     <= 1'b0;
         armed_q    <= 1'b0;
         data_out_q <= '0;
         valid_q    <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values regardless of statement order.
         state_q    <= state_d;
         acc_q      <= acc_d;
         count_q    <= count_d;
         shift_q    <= shift_d;
         conv_q     <= conv_finished;
         armed_q    <= armed_q | ~conv_finished;
         data_out_q <= data_out_d;
         valid_q    <= valid_d;
         overrun_q  <= overrun_d;
      end
   end

   assign data_out   = data_out_q;
   assign data_valid = valid_q;
   assign busy       = (state_q == ACCUM);
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_adc_result_averager.sv
// Testbench for adc_result_averager: table of complete blocks, hand-written
// corner sequences, and a randomized run against a sample-queue model.

module tb_adc_result_averager;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        conv_finished;
   logic [11:0] result;
   logic [2:0]  avg_control;
   logic        data_ready;
   logic        clear_overrun;
   logic [11:0] data_out;
   logic        data_valid;
   logic        busy;
   logic        overrun;

   int n_checks = 0;
   int n_fail   = 0;

   adc_result_averager #(.IN_WIDTH(12), .AVG_LOG2_MAX(7)) dut (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
      .conv_finished (conv_finished),
      .result        (result),
      .avg_control   (avg_control),
      .data_ready    (data_ready),
      .clear_overrun (clear_overrun),
      .data_out      (data_out),
      .data_valid    (data_valid),
      .busy          (busy),
      .overrun       (overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  avg;
      int          base;
      int          step;
      logic [11:0] expected;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Advance to just past the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample_hi(input logic [11:0] v);
      conv_finished = 1'b1;
      result        = v;
      tick();
   endtask

   task automatic sample_lo();
      conv_finished = 1'b0;
      tick();
   endtask

   task automatic pulse(input logic [11:0] v);
      sample_hi(v);
      sample_lo();
   endtask

   // Reset with inputs idle; returns between edges with rst released.
   task automatic do_reset();
      conv_finished = 1'b0;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();
   endtask

   // Behavioural model state
   bit       m_prev, m_armed, m_valid, m_ovr;
   int       m_n;
   int       m_out;
   int       m_q[$];

   task automatic model_reset();
      m_prev  = 1'b0;
      m_armed = 1'b0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_n     = 1;
      m_out   = 0;
      m_q.delete();
   endtask

   // One clock edge of the model, using the inputs present before the edge.
   task automatic model_edge();
      bit ev, done, ready_now;
      int sum;
      ev        = conv_finished && !m_prev && m_armed;
      ready_now = data_ready;
      done      = 1'b0;
      sum       = 0;
      if (m_valid && ready_now) m_valid = 1'b0;
      if (!en) begin
         m_q.delete();
      end else if (ev) begin
         if (m_q.size() == 0) m_n = 1 << avg_control;
         m_q.push_back(int'(result));
         if (m_q.size() == m_n) begin
            foreach (m_q[k]) sum += m_q[k];
            m_q.delete();
            done = 1'b1;
         end
      end
      if (done) begin
         if (!m_valid) begin
            m_out   = sum / m_n;
            m_valid = 1'b1;
         end else begin
            m_ovr = 1'b1;
         end
      end else if (clear_overrun) begin
         m_ovr = 1'b0;
      end
      if (done && m_ovr && clear_overrun && !m_valid) m_ovr = 1'b0;
      m_armed = m_armed || !conv_finished;
      m_prev  = conv_finished;
   endtask

   initial begin
      vecs[0] = '{3'd0, 'h123, 0,  12'h123};
      vecs[1] = '{3'd0, 'hFFF, 0,  12'hFFF};
      vecs[2] = '{3'd2, 10,    1,  12'd11};
      vecs[3] = '{3'd1, 7,     1,  12'd7};
      vecs[4] = '{3'd3, 100,   3,  12'd110};
      vecs[5] = '{3'd7, 'hFFF, 0,  12'hFFF};
      vecs[6] = '{3'd4, 0,     17, 12'd127};

      // Reset with conv_finished already high at release.
      rst = 1'b0; en = 1'b1; conv_finished = 1'b1; result = 12'h3C;
      avg_control = 3'd0; data_ready = 1'b0; clear_overrun = 1'b0;
      #1;
      check("reset data_out", 32'(data_out), 32'h0);
      check("reset data_valid", 32'(data_valid), 32'h0);
      check("reset busy", 32'(busy), 32'h0);
      check("reset overrun", 32'(overrun), 32'h0);
      tick();
      rst = 1'b1;
      tick();
      tick();
      check("high-at-release not counted", 32'(data_valid), 32'h0);
      sample_lo();
      sample_hi(12'h3C);
      check("first event after release", 32'(data_out), 32'h3C);
      check("first event valid", 32'(data_valid), 32'h1);
      data_ready = 1'b1;
      sample_lo();
      check("consumed after ready", 32'(data_valid), 32'h0);

      // Table of complete blocks with downstream always ready.
      foreach (vecs[i]) begin
         int n;
         avg_control = vecs[i].avg;
         n = 1 << vecs[i].avg;
         for (int s = 0; s < n; s++) begin
            sample_hi(12'(vecs[i].base + s * vecs[i].step));
            if (s == 0 && n > 1) check($sformatf("vec%0d busy after first", i), 32'(busy), 32'h1);
            if (s == n - 1) begin
               check($sformatf("vec%0d data_out", i), 32'(data_out), 32'(vecs[i].expected));
               check($sformatf("vec%0d data_valid", i), 32'(data_valid), 32'h1);
               check($sformatf("vec%0d busy at end", i), 32'(busy), 32'h0);
            end
            sample_lo();
         end
         check($sformatf("vec%0d valid consumed", i), 32'(data_valid), 32'h0);
      end

      // Overrun: two single-sample blocks with downstream stalled.
      data_ready = 1'b0; avg_control = 3'd0;
      pulse(12'hAAA);
      pulse(12'h555);
      check("overrun keeps first", 32'(data_out), 32'hAAA);
      check("overrun flag", 32'(overrun), 32'h1);
      tick();
      check("overrun held", 32'(overrun), 32'h1);
      check("stall holds valid", 32'(data_valid), 32'h1);
      clear_overrun = 1'b1;
      tick();
      clear_overrun = 1'b0;
      check("overrun cleared", 32'(overrun), 32'h0);
      // Accept and completion on the same edge: reload, valid stays high.
      data_ready = 1'b1;
      sample_hi(12'h321);
      check("reload on accept", 32'(data_out), 32'h321);
      check("valid stays on reload", 32'(data_valid), 32'h1);
      check("no overrun on reload", 32'(overrun), 32'h0);
      sample_lo();
      check("reload consumed", 32'(data_valid), 32'h0);
      // Simultaneous set and clear of overrun: set wins.
      data_ready = 1'b0;
      pulse(12'h111);
      clear_overrun = 1'b1;
      sample_hi(12'h222);
      clear_overrun = 1'b0;
      check("set beats clear", 32'(overrun), 32'h1);
      sample_lo();
      clear_overrun = 1'b1; data_ready = 1'b1;
      tick();
      clear_overrun = 1'b0;
      check("drain valid", 32'(data_valid), 32'h0);

      // Enable drop discards a partial block.
      avg_control = 3'd2;
      pulse(12'd9);
      pulse(12'd9);
      check("busy mid-block", 32'(busy), 32'h1);
      en = 1'b0;
      tick();
      check("en low idles", 32'(busy), 32'h0);
      pulse(12'd3);
      check("event ignored with en low", 32'(busy), 32'h0);
      en = 1'b1;
      for (int s = 0; s < 3; s++) pulse(12'd5);
      sample_hi(12'd5);
      check("fresh block after en drop", 32'(data_out), 32'd5);
      sample_lo();

      // avg_control changes mid-block are ignored.
      avg_control = 3'd1;
      pulse(12'd4);
      avg_control = 3'd0;
      sample_hi(12'd6);
      check("latched block size", 32'(data_out), 32'd5);
      check("latched block valid", 32'(data_valid), 32'h1);
      sample_lo();

      // Reset mid-block with a held output word.
      data_ready = 1'b0; avg_control = 3'd0;
      pulse(12'h7AB);
      avg_control = 3'd2;
      pulse(12'd1); pulse(12'd2); pulse(12'd3);
      rst = 1'b0;
      #1;
      check("mid-block reset data_out", 32'(data_out), 32'h0);
      check("mid-block reset valid", 32'(data_valid), 32'h0);
      check("mid-block reset busy", 32'(busy), 32'h0);
      rst = 1'b1;
      data_ready = 1'b1;
      tick();
      pulse(12'd20); pulse(12'd21); pulse(12'd22);
      sample_hi(12'd23);
      check("fresh average after reset", 32'(data_out), 32'd21);
      sample_lo();

      // Randomized run against the model.
      do_reset();
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         conv_finished = 1'($urandom_range(0, 1));
         result        = 12'($urandom_range(0, 4095));
         avg_control   = 3'($urandom_range(0, 3));
         en            = ($urandom_range(0, 29) != 0);
         data_ready    = ($urandom_range(0, 9) < 6);
         clear_overrun = ($urandom_range(0, 9) == 0);
         model_edge();
         tick();
         check("rand data_valid", 32'(data_valid), 32'(m_valid));
         check("rand overrun", 32'(overrun), 32'(m_ovr));
         check("rand busy", 32'(busy), 32'(m_q.size() != 0));
         if (m_valid) check("rand data_out", 32'(data_out), 32'(m_out));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
